dt_coeff_gen: RTL and testbench

- Upstream time-parameter stage of the covariance-prediction datapath.
- From one IEEE-754 double delta_t it produces the shared time coefficients consumed by every CMU_PHi* block: delta_t, half_dt2 = dt^2/2, two3_dt3 = (2/3)·dt^3 and sixth_dt4 = dt^4/6.
- Uses two shared fp_multiplier instances, sequenced by an FSM.
- Results are held stable until the next start.

---
 rtl/kalman_fp_pkg.sv | 74 +++++++
 rtl/fp_multiplier.sv | 43 ++++
 rtl/dt_coeff_gen.sv | 164 ++++++++++++++++
 tb/tb_dt_coeff_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/kalman_fp_pkg.sv
// Shared definitions for the Kalman floating-point datapath.
//   FP_DBL_WIDTH : default operand width (IEEE-754 double)
//   FP_*         : double-precision constants used by the coefficient stages
//   round_state_e: sequencing states of the time-coefficient generator
//   fp_mul       : double multiply, round-to-nearest-even, subnormals flushed
package kalman_fp_pkg;

  localparam int          FP_DBL_WIDTH = 64;
  localparam logic [63:0] FP_ZERO      = 64'h0000000000000000;
  localparam logic [63:0] FP_HALF      = 64'h3FE0000000000000;
  localparam logic [63:0] FP_TWO3      = 64'h3FE5555555555555;
  localparam logic [63:0] FP_SIXTH     = 64'h3FC5555555555555;
  localparam logic [63:0] FP_QNAN      = 64'h7FF8000000000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_R1,
    S_R2,
    S_R3,
    S_R4,
    S_DONE
  } round_state_e;

  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic               s;
    logic [10:0]        ea;
    logic [10:0]        eb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [105:0]       prod;
    logic [52:0]        mant;
    logic               rnd;
    logic [53:0]        mr;
    logic [51:0]        frac;
    logic signed [13:0] e;
    logic [63:0]        r;
    s      = a[63] ^ b[63];
    ea     = a[62:52];
    eb     = b[62:52];
    // Subnormal inputs are treated as zero.
    a_zero = (ea == 11'h000);
    b_zero = (eb == 11'h000);
    a_inf  = (ea == 11'h7FF) && (a[51:0] == 52'd0);
    b_inf  = (eb == 11'h7FF) && (b[51:0] == 52'd0);
    a_nan  = (ea == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (eb == 11'h7FF) && (b[51:0] != 52'd0);
    prod   = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    e      = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;
    // Normalise: product of two [1,2) mantissas lies in [1,4).
    if (prod[105]) begin
      mant = prod[105:53];
      rnd  = prod[52] & ((|prod[51:0]) | prod[53]);
      e    = e + 14'sd1;
    end else begin
      mant = prod[104:52];
      rnd  = prod[51] & ((|prod[50:0]) | prod[52]);
    end
    mr = {1'b0, mant} + 54'(rnd);
    // Rounding carry-out renormalises to 1.0 x 2^(e+1).
    if (mr[53]) begin
      frac = mr[52:1];
      e    = e + 14'sd1;
    end else begin
      frac = mr[51:0];
    end
    if (a_nan || b_nan)              r = FP_QNAN;
    else if (a_inf || b_inf)         r = (a_zero || b_zero) ? FP_QNAN : {s, 11'h7FF, 52'd0};
    else if (a_zero || b_zero)       r = {s, 63'd0};
    else if (e >= 14'sd2047)         r = {s, 11'h7FF, 52'd0};
    else if (e <= 14'sd0)            r = {s, 63'd0};
    else                             r = {s, e[10:0], frac};
    return r;
  endfunction

endpackage

// File: rtl/fp_multiplier.sv
// Multi-cycle IEEE-754 double multiplier with a go/finish handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   go_i       : single-cycle request; operands sampled in the same cycle
//   a_i, b_i   : operands
//   ready_o    : a go may be registered this cycle for the following cycle
//   finish_o   : one-cycle pulse LATENCY cycles after go_i
//   result_o   : product, held until the next go
module fp_multiplier
  import kalman_fp_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        ready_o,
  output logic        finish_o,
  output logic [63:0] result_o
);

  logic [7:0]  cnt_q;
  logic [63:0] res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      res_q <= FP_ZERO;
    end else if (go_i && (cnt_q == 8'd0)) begin
      cnt_q <= 8'(LATENCY);
      res_q <= fp_mul(a_i, b_i);
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign finish_o = (cnt_q == 8'd1);
  // Ready during the finish cycle: a go registered now lands when the unit is idle.
  assign ready_o  = (cnt_q <= 8'd1);
  assign result_o = res_q;

endmodule

// File: rtl/dt_coeff_gen.sv
// Time-coefficient generator for the covariance-prediction datapath.
// From delta_t it produces dt, dt^2/2, (2/3)dt^3 and dt^4/6 using two shared
// multipliers sequenced over four rounds.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : run request, sampled only in S_IDLE
//   delta_t_in  : time step, captured on accepted start
//   delta_t, half_dt2, two3_dt3, sixth_dt4 : coefficient outputs
//   busy        : accepted start until valid_out
//   valid_out   : one-cycle pulse, all outputs updated
module dt_coeff_gen
  import kalman_fp_pkg::*;
#(
  parameter int DBL_WIDTH = FP_DBL_WIDTH,
  parameter int MUL0_LAT  = 3,
  parameter int MUL1_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DBL_WIDTH-1:0] delta_t_in,
  output logic [DBL_WIDTH-1:0] delta_t,
  output logic [DBL_WIDTH-1:0] half_dt2,
  output logic [DBL_WIDTH-1:0] two3_dt3,
  output logic [DBL_WIDTH-1:0] sixth_dt4,
  output logic                 busy,
  output logic                 valid_out
);

  round_state_e         state_q, tgt, iss_st;
  logic [DBL_WIDTH-1:0] dt_q, dt2_q, dt3_q, dt4_q, half_q, two3_q, sixth_q;
  logic [DBL_WIDTH-1:0] op0a_q, op0b_q, op1a_q, op1b_q;
  logic [DBL_WIDTH-1:0] a0_d, b0_d, a1_d, b1_d;
  logic [DBL_WIDTH-1:0] dt_src, dt2_src, dt3_src, dt4_src;
  logic [DBL_WIDTH-1:0] res0, res1;
  logic                 go0_q, go1_q, done0_q, done1_q, issued_q, busy_q, valid_q;
  logic                 rdy0, rdy1, fin0, fin1, all0, all1;
  logic                 adv, use0, use1, do_issue;

  fp_multiplier #(.LATENCY(MUL0_LAT)) u_mul0 (
    .clk(clk), .rst_n(rst_n), .go_i(go0_q), .a_i(op0a_q), .b_i(op0b_q),
    .ready_o(rdy0), .finish_o(fin0), .result_o(res0)
  );

  fp_multiplier #(.LATENCY(MUL1_LAT)) u_mul1 (
    .clk(clk), .rst_n(rst_n), .go_i(go1_q), .a_i(op1a_q), .b_i(op1b_q),
    .ready_o(rdy1), .finish_o(fin1), .result_o(res1)
  );

  // A finish arriving this cycle counts as done so the round can advance now.
  assign all0 = done0_q | fin0;
  assign all1 = done1_q | fin1;

  // Operands for a round issued on the transition edge come straight from the
  // multiplier result, which is held until that unit's next go.
  assign dt_src  = (state_q == S_IDLE) ? delta_t_in : dt_q;
  assign dt2_src = (state_q == S_R1)   ? res0       : dt2_q;
  assign dt3_src = (state_q == S_R2)   ? res0       : dt3_q;
  assign dt4_src = (state_q == S_R3)   ? res0       : dt4_q;

  always_comb begin
    adv  = 1'b0;
    tgt  = state_q;
    case (state_q)
      S_IDLE: begin adv = start;                    tgt = S_R1;   end
      S_R1:   begin adv = issued_q & all0;          tgt = S_R2;   end
      S_R2:   begin adv = issued_q & all0 & all1;   tgt = S_R3;   end
      S_R3:   begin adv = issued_q & all0 & all1;   tgt = S_R4;   end
      S_R4:   begin adv = issued_q & all1;          tgt = S_DONE; end
      S_DONE: begin adv = 1'b1;                     tgt = S_IDLE; end
      default: begin adv = 1'b1;                    tgt = S_IDLE; end
    endcase
    iss_st = adv ? tgt : state_q;
    use0 = 1'b0;
    use1 = 1'b0;
    a0_d = FP_ZERO;
    b0_d = FP_ZERO;
    a1_d = FP_ZERO;
    b1_d = FP_ZERO;
    case (iss_st)
      S_R1: begin use0 = 1'b1; a0_d = dt_src;  b0_d = dt_src; end
      S_R2: begin
        use0 = 1'b1; a0_d = dt2_src; b0_d = dt_src;
        use1 = 1'b1; a1_d = dt2_src; b1_d = FP_HALF;
      end
      S_R3: begin
        use0 = 1'b1; a0_d = dt2_src; b0_d = dt2_src;
        use1 = 1'b1; a1_d = dt3_src; b1_d = FP_TWO3;
      end
      S_R4: begin use1 = 1'b1; a1_d = dt4_src; b1_d = FP_SIXTH; end
      default: ;
    endcase
    // One issue per state entry; a dual round waits until both units are ready.
    do_issue = (adv | ~issued_q) & (use0 | use1) & (~use0 | rdy0) & (~use1 | rdy1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dt_q     <= FP_ZERO;
      dt2_q    <= FP_ZERO;
      dt3_q    <= FP_ZERO;
      dt4_q    <= FP_ZERO;
      half_q   <= FP_ZERO;
      two3_q   <= FP_ZERO;
      sixth_q  <= FP_ZERO;
      op0a_q   <= FP_ZERO;
      op0b_q   <= FP_ZERO;
      op1a_q   <= FP_ZERO;
      op1b_q   <= FP_ZERO;
      go0_q    <= 1'b0;
      go1_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      issued_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      go0_q   <= do_issue & use0;
      go1_q   <= do_issue & use1;
      // valid_out trails the S_DONE cycle by one register.
      valid_q <= (state_q == S_DONE);
      if (do_issue) begin
        op0a_q <= a0_d;
        op0b_q <= b0_d;
        op1a_q <= a1_d;
        op1b_q <= b1_d;
      end
      if (adv) begin
        state_q  <= tgt;
        done0_q  <= 1'b0;
        done1_q  <= 1'b0;
        issued_q <= do_issue;
      end else begin
        if (do_issue) issued_q <= 1'b1;
        if (fin0 && (state_q != S_IDLE)) done0_q <= 1'b1;
        if (fin1 && (state_q != S_IDLE)) done1_q <= 1'b1;
      end
      // Results are captured on each unit's finish within its round.
      case (state_q)
        S_IDLE: if (start) begin dt_q <= delta_t_in; busy_q <= 1'b1; end
        S_R1:   if (fin0) dt2_q <= res0;
        S_R2: begin
          if (fin0) dt3_q  <= res0;
          if (fin1) half_q <= res1;
        end
        S_R3: begin
          if (fin0) dt4_q  <= res0;
          if (fin1) two3_q <= res1;
        end
        S_R4:   if (fin1) sixth_q <= res1;
        S_DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign delta_t   = dt_q;
  assign half_dt2  = half_q;
  assign two3_dt3  = two3_q;
  assign sixth_dt4 = sixth_q;
  assign busy      = busy_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_dt_coeff_gen.sv
module tb_dt_coeff_gen;

  localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] D_TWO  = 64'h4000000000000000;
  localparam logic [63:0] D_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] D_ZERO = 64'h0000000000000000;
  localparam int          LAT_MAIN = 4 * 3 + 6;
  // Skewed unit: R1 takes 3+1, the three mul1 rounds take 8+1 each, plus 2.
  localparam int          LAT_SKEW = (3 + 1) + 3 * (8 + 1) + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_s;
  logic [63:0] dt_in, dt_s;
  logic [63:0] delta_t, half_dt2, two3_dt3, sixth_dt4;
  logic [63:0] delta_t_s, half_dt2_s, two3_dt3_s, sixth_dt4_s;
  logic        busy, valid_out, busy_s, valid_s;

  int tests = 0;
  int fails = 0;
  int go0_cnt = 0;
  int go1_cnt = 0;

  always #5 clk = ~clk;

  dt_coeff_gen #(.DBL_WIDTH(64), .MUL0_LAT(3), .MUL1_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delta_t_in(dt_in),
    .delta_t(delta_t), .half_dt2(half_dt2), .two3_dt3(two3_dt3), .sixth_dt4(sixth_dt4),
    .busy(busy), .valid_out(valid_out)
  );

  dt_coeff_gen #(.DBL_WIDTH(64), .MUL0_LAT(3), .MUL1_LAT(8)) dut_sk (
    .clk(clk), .rst_n(rst_n), .start(start_s), .delta_t_in(dt_s),
    .delta_t(delta_t_s), .half_dt2(half_dt2_s), .two3_dt3(two3_dt3_s), .sixth_dt4(sixth_dt4_s),
    .busy(busy_s), .valid_out(valid_s)
  );

  always @(posedge clk) begin
    if (dut_sk.go0_q) go0_cnt <= go0_cnt + 1;
    if (dut_sk.go1_q) go1_cnt <= go1_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_main(input logic [63:0] dt, output int lat);
    start = 1'b1;
    dt_in = dt;
    tick;
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    lat = 1;
    while (!valid_out && lat < 100) begin
      tick;
      lat++;
    end
    chk("busy_at_valid", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_sk(input logic [63:0] dt, output int lat);
    start_s = 1'b1;
    dt_s    = dt;
    tick;
    start_s = 1'b0;
    lat = 1;
    while (!valid_s && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic chk_main(input string tag, input logic [63:0] e_dt, input logic [63:0] e_h,
                          input logic [63:0] e_t, input logic [63:0] e_s);
    chk({tag, "_delta_t"}, delta_t, e_dt);
    chk({tag, "_half_dt2"}, half_dt2, e_h);
    chk({tag, "_two3_dt3"}, two3_dt3, e_t);
    chk({tag, "_sixth_dt4"}, sixth_dt4, e_s);
  endtask

  initial begin
    int lat;
    int pulses;
    int g0, g1;
    rst_n   = 1'b0;
    start   = 1'b0;
    dt_in   = D_ZERO;
    start_s = 1'b0;
    dt_s    = D_ZERO;
    tick;
    tick;
    chk_main("reset", D_ZERO, D_ZERO, D_ZERO, D_ZERO);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, valid_out}, 64'd0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // dt = 1.0
    run_main(D_ONE, lat);
    chk("t1_latency", 64'(lat), 64'(LAT_MAIN));
    chk_main("t1", D_ONE, 64'h3FE0000000000000, 64'h3FE5555555555555, 64'h3FC5555555555555);
    tick;
    chk("t1_valid_single", {63'd0, valid_out}, 64'd0);

    // dt = 2.0
    run_main(D_TWO, lat);
    chk("t2_latency", 64'(lat), 64'(LAT_MAIN));
    chk_main("t2", D_TWO, 64'h4000000000000000, 64'h4015555555555555, 64'h4005555555555555);
    tick;

    // dt = 0, then dt = 0.5
    run_main(D_ZERO, lat);
    chk("t3_latency", 64'(lat), 64'(LAT_MAIN));
    chk_main("t3", D_ZERO, D_ZERO, D_ZERO, D_ZERO);
    tick;
    chk("t3_valid_single", {63'd0, valid_out}, 64'd0);
    run_main(D_HALF, lat);
    chk_main("t3b", D_HALF, 64'h3FC0000000000000, 64'h3FB5555555555555, 64'h3F85555555555555);
    tick;

    // start while busy is ignored
    start = 1'b1;
    dt_in = D_TWO;
    tick;
    start = 1'b0;
    tick;
    tick;
    start = 1'b1;
    dt_in = D_ONE;
    tick;
    start = 1'b0;
    chk("t4_busy_held", {63'd0, busy}, 64'd1);
    chk("t4_delta_t_kept", delta_t, D_TWO);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out) pulses++;
      tick;
    end
    chk("t4_valid_pulses", 64'(pulses), 64'd1);
    chk_main("t4", D_TWO, 64'h4000000000000000, 64'h4015555555555555, 64'h4005555555555555);

    // mul1 finishing 5 cycles after mul0
    g0 = go0_cnt;
    g1 = go1_cnt;
    run_sk(D_TWO, lat);
    chk("t5_latency", 64'(lat), 64'(LAT_SKEW));
    chk("t5_delta_t", delta_t_s, D_TWO);
    chk("t5_half_dt2", half_dt2_s, 64'h4000000000000000);
    chk("t5_two3_dt3", two3_dt3_s, 64'h4015555555555555);
    chk("t5_sixth_dt4", sixth_dt4_s, 64'h4005555555555555);
    tick;
    chk("t5_go0_count", 64'(go0_cnt - g0), 64'd3);
    chk("t5_go1_count", 64'(go1_cnt - g1), 64'd3);
    run_sk(D_ONE, lat);
    chk("t5b_half_dt2", half_dt2_s, 64'h3FE0000000000000);
    chk("t5b_two3_dt3", two3_dt3_s, 64'h3FE5555555555555);
    chk("t5b_sixth_dt4", sixth_dt4_s, 64'h3FC5555555555555);
    tick;

    // reset during S_R3
    start = 1'b1;
    dt_in = D_TWO;
    tick;
    start = 1'b0;
    repeat (9) tick;
    rst_n = 1'b0;
    tick;
    tick;
    chk_main("t6_reset", D_ZERO, D_ZERO, D_ZERO, D_ZERO);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_valid", {63'd0, valid_out}, 64'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid_out) pulses++;
      tick;
    end
    chk("t6_no_valid", 64'(pulses), 64'd0);
    run_main(D_ONE, lat);
    chk("t6_latency", 64'(lat), 64'(LAT_MAIN));
    chk_main("t6_rerun", D_ONE, 64'h3FE0000000000000, 64'h3FE5555555555555, 64'h3FC5555555555555);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
